mem_bist_seq: RTL and testbench

- Built-in self-test sequencer for the 32-bit data memory (8-bit address, write-enable, 32-bit write data, 32-bit read data).
- On `start`, fills an address range with one of the four bench patterns, reads it back and compares each word.
- Reports pass/fail, error count and first failing address.
- Drives the seven-segment display data bus, so the board shows the result without manual switch stepping.

---
 rtl/mem_bist_seq.sv | 184 ++++++++++++++++++
 tb/tb_mem_bist_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bist_seq.sv
// BIST sequencer for the 32-bit data memory: fill a range with a pattern, read it back, report results.
// Optional MEMSEQ_ADDR_MIX_EN: XORs the address into each word so aliased address lines are caught.
module mem_bist_seq #(
  parameter int          ADDR_STEP = 4,
  parameter int          RD_LAT    = 1,
  parameter logic [31:0] PAT0      = 32'h11223344,
  parameter logic [31:0] PAT1      = 32'h44332211,
  parameter logic [31:0] PAT2      = 32'hFFFFFFFF,
  parameter logic [31:0] PAT3      = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  pattern_sel,
  input  logic [7:0]  addr_lo,
  input  logic [7:0]  addr_hi,
  output logic        mem_write,
  output logic [7:0]  dm_addr,
  output logic [31:0] mw_data,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  err_cnt,
  output logic [7:0]  fail_addr,
  output logic [31:0] disp_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_RD_ADDR,
    S_RD_WAIT,
    S_CMP,
    S_DONE
  } state_t;

  state_t      state, state_nx;
  logic        start_q;
  logic [7:0]  lo_r, hi_r, cur, cur_nx;
  logic [1:0]  sel_r;
  logic [7:0]  wcnt, wcnt_nx;
  logic        launch, empty_range, enter_done;
  logic [8:0]  step_sum;
  logic        last_word;
  logic [31:0] base_word, exp_word;
  logic        mismatch;
  logic [7:0]  err_nx, fail_nx;

  assign launch      = start & ~start_q;
  assign empty_range = addr_hi < addr_lo;
  // 9-bit sum so a step past 0xFF ends the range instead of wrapping to 0x00
  assign step_sum    = {1'b0, cur} + 9'(ADDR_STEP);
  assign last_word   = step_sum > {1'b0, hi_r};
  assign mismatch    = mem_rdata != exp_word;

  always_comb begin
    base_word = PAT0;
    case (sel_r)
      2'd0: base_word = PAT0;
      2'd1: base_word = PAT1;
      2'd2: base_word = PAT2;
      default: base_word = PAT3;
    endcase
`ifdef MEMSEQ_ADDR_MIX_EN
    exp_word = base_word ^ {4{cur}};
`else
    exp_word = base_word;
`endif
  end

  always_comb begin
    err_nx  = err_cnt;
    fail_nx = fail_addr;
    if (state == S_CMP && mismatch) begin
      if (err_cnt != 8'hFF) err_nx = err_cnt + 8'd1;
      if (err_cnt == 8'h00) fail_nx = cur;
    end
  end

  always_comb begin
    state_nx   = state;
    cur_nx     = cur;
    wcnt_nx    = wcnt;
    enter_done = 1'b0;
    mem_write  = 1'b0;
    dm_addr    = 8'h00;
    mw_data    = 32'h00000000;
    busy       = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (launch) begin
          cur_nx = addr_lo;
          if (empty_range) begin
            state_nx   = S_DONE;
            enter_done = 1'b1;
          end else begin
            state_nx = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        busy      = 1'b1;
        mem_write = 1'b1;
        dm_addr   = cur;
        mw_data   = exp_word;
        if (last_word) begin
          cur_nx   = lo_r;
          state_nx = S_RD_ADDR;
        end else begin
          cur_nx = step_sum[7:0];
        end
      end
      S_RD_ADDR: begin
        busy    = 1'b1;
        dm_addr = cur;
        wcnt_nx = 8'h00;
        // RD_LAT of 0 or 1 needs no extra wait cycles before the compare
        if (RD_LAT <= 1) state_nx = S_CMP;
        else             state_nx = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        busy    = 1'b1;
        dm_addr = cur;
        if (wcnt == 8'(RD_LAT - 2)) state_nx = S_CMP;
        else                        wcnt_nx  = wcnt + 8'd1;
      end
      S_CMP: begin
        busy    = 1'b1;
        dm_addr = cur;
        if (last_word) begin
          state_nx   = S_DONE;
          enter_done = 1'b1;
        end else begin
          cur_nx   = step_sum[7:0];
          state_nx = S_RD_ADDR;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      start_q   <= 1'b1;
      cur       <= 8'h00;
      lo_r      <= 8'h00;
      hi_r      <= 8'h00;
      sel_r     <= 2'd0;
      wcnt      <= 8'h00;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_cnt   <= 8'h00;
      fail_addr <= 8'h00;
      disp_data <= 32'h00000000;
    end else begin
      state   <= state_nx;
      start_q <= start;
      cur     <= cur_nx;
      wcnt    <= wcnt_nx;
      done    <= enter_done;
      if ((state == S_IDLE || state == S_DONE) && launch) begin
        lo_r      <= addr_lo;
        hi_r      <= addr_hi;
        sel_r     <= pattern_sel;
        err_cnt   <= 8'h00;
        fail_addr <= 8'h00;
        pass      <= empty_range;
        if (empty_range) disp_data <= 32'hAA000000;
      end
      if (state == S_CMP) begin
        err_cnt   <= err_nx;
        fail_addr <= fail_nx;
        disp_data <= mem_rdata;
        if (last_word) begin
          pass      <= (err_nx == 8'h00);
          disp_data <= {(err_nx == 8'h00) ? 8'hAA : 8'hEE, fail_nx, 8'h00, err_nx};
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_bist_seq.sv
// Bench for mem_bist_seq: faulty-memory model plus a range-walking reference model of the BIST result.
module tb_mem_bist_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start_a, start_b;
  logic [1:0]  psel;
  logic [7:0]  lo, hi;

  logic        mw_a, busy_a, done_a, pass_a;
  logic [7:0]  addr_a, err_a, fa_a;
  logic [31:0] wd_a, rd_a, disp_a;
  logic        mw_b, busy_b, done_b, pass_b;
  logic [7:0]  addr_b, err_b, fa_b;
  logic [31:0] wd_b, rd_b, disp_b;

  mem_bist_seq #(.ADDR_STEP(4)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .pattern_sel(psel), .addr_lo(lo), .addr_hi(hi),
    .mem_write(mw_a), .dm_addr(addr_a), .mw_data(wd_a), .mem_rdata(rd_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a), .fail_addr(fa_a),
    .disp_data(disp_a));

  mem_bist_seq #(.ADDR_STEP(1)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .pattern_sel(psel), .addr_lo(lo), .addr_hi(hi),
    .mem_write(mw_b), .dm_addr(addr_b), .mw_data(wd_b), .mem_rdata(rd_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b), .fail_addr(fa_b),
    .disp_data(disp_b));

  // Synchronous-read memories with per-word stuck-at masks (AND for stuck-0, OR for stuck-1)
  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  logic [31:0] andm  [256];
  logic [31:0] orm   [256];

  always @(posedge clk) begin
    if (mw_a) mem_a[addr_a] <= wd_a;
    rd_a <= (mem_a[addr_a] & andm[addr_a]) | orm[addr_a];
    if (mw_b) mem_b[addr_b] <= wd_b;
    rd_b <= (mem_b[addr_b] & andm[addr_b]) | orm[addr_b];
  end

  bit          use_b = 1'b0;
  logic        o_mw, o_busy, o_done, o_pass;
  logic [7:0]  o_addr, o_err, o_fa;
  logic [31:0] o_wd, o_disp;
  assign o_mw   = use_b ? mw_b   : mw_a;
  assign o_busy = use_b ? busy_b : busy_a;
  assign o_done = use_b ? done_b : done_a;
  assign o_pass = use_b ? pass_b : pass_a;
  assign o_addr = use_b ? addr_b : addr_a;
  assign o_err  = use_b ? err_b  : err_a;
  assign o_fa   = use_b ? fa_b   : fa_a;
  assign o_wd   = use_b ? wd_b   : wd_a;
  assign o_disp = use_b ? disp_b : disp_a;

  logic [39:0] wlog  [$];
  logic [39:0] exp_w [$];
  always @(negedge clk) if (o_mw) wlog.push_back({o_addr, o_wd});

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] base_pat(input logic [1:0] s);
    logic [31:0] t [4];
    t = '{32'h11223344, 32'h44332211, 32'hFFFFFFFF, 32'h00000000};
    return t[s];
  endfunction

  // Walk the inclusive range at the given step and predict what a correct sequencer reports
  task automatic model(input logic [7:0] l, input logic [7:0] h, input logic [1:0] s,
                       input int step, output int n, output int errs, output logic [7:0] fa);
    logic [31:0] w, rdv;
    logic [7:0]  a8;
    exp_w.delete();
    n = 0; errs = 0; fa = 8'h00;
    for (int a = int'(l); a <= int'(h); a += step) begin
      a8 = a[7:0];
      w  = base_pat(s);
`ifdef MEMSEQ_ADDR_MIX_EN
      w  = w ^ {4{a8}};
`endif
      exp_w.push_back({a8, w});
      n++;
      rdv = (w & andm[a8]) | orm[a8];
      if (rdv !== w) begin
        if (errs == 0) fa = a8;
        if (errs < 255) errs++;
      end
    end
  endtask

  task automatic run(input bit b, input logic [7:0] l, input logic [7:0] h,
                     input logic [1:0] s, input string tag);
    int n, errs, lat;
    logic [7:0]  fa;
    bit got, same;
    use_b = b;
    model(l, h, s, b ? 1 : 4, n, errs, fa);
    @(negedge clk);
    lo = l; hi = h; psel = s;
    wlog.delete();
    if (b) start_b = 1'b1; else start_a = 1'b1;
    got = 1'b0; lat = 0;
    for (int k = 1; k <= 1000; k++) begin
      @(posedge clk); #1;
      if (o_done) begin lat = k; got = 1'b1; break; end
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, lat, 3 * n + 1);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_err_cnt"}, 32'(o_err), errs);
    check({tag, "_fail_addr"}, 32'(o_fa), 32'(fa));
    check({tag, "_pass"}, 32'(o_pass), 32'(errs == 0));
    check({tag, "_disp"}, o_disp, {(errs == 0) ? 8'hAA : 8'hEE, fa, 8'h00, 8'(errs)});
    check({tag, "_nwrites"}, wlog.size(), n);
    if (wlog.size() == n) begin
      same = 1'b1;
      foreach (exp_w[i]) if (wlog[i] !== exp_w[i]) same = 1'b0;
      check({tag, "_write_seq"}, 32'(same), 32'd1);
    end
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    @(posedge clk); #1;
    check({tag, "_done_pulse_len"}, 32'(o_done), 32'd0);
    check({tag, "_pass_held"}, 32'(o_pass), 32'(errs == 0));
  endtask

  task automatic clear_faults();
    for (int i = 0; i < 256; i++) begin
      andm[i] = 32'hFFFFFFFF;
      orm[i]  = 32'h00000000;
    end
  endtask

  initial begin
    logic [7:0] rl, rh, tmp;
    bit wrote;
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 32'h0; mem_b[i] = 32'h0;
    end
    clear_faults();
    rst = 1'b0; start_a = 1'b0; start_b = 1'b0; psel = 2'd0; lo = 8'h00; hi = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_write", 32'(mw_a), 32'd0);
    check("rst_dm_addr", 32'(addr_a), 32'd0);
    check("rst_mw_data", wd_a, 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_pass", 32'(pass_a), 32'd0);
    check("rst_err_cnt", 32'(err_a), 32'd0);
    check("rst_fail_addr", 32'(fa_a), 32'd0);
    check("rst_disp", disp_a, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    run(1'b0, 8'h00, 8'h0C, 2'd0, "basic");
    check("basic_disp_const", disp_a, 32'hAA000000);

    andm[8] = 32'hFFFFFFFE;
    run(1'b0, 8'h00, 8'h10, 2'd2, "stuck08");
    clear_faults();

    run(1'b0, 8'h20, 8'h10, 2'd1, "hi_lt_lo");
    run(1'b0, 8'hF8, 8'hFF, 2'd1, "top_range");

    for (int i = 0; i < 256; i++) andm[i] = 32'h0;
    run(1'b0, 8'h00, 8'hFC, 2'd2, "all64_bad");
    run(1'b1, 8'h00, 8'hFF, 2'd2, "sat256");
    clear_faults();

    // Reset in the middle of the fill, with start held high afterwards
    use_b = 1'b0;
    @(negedge clk);
    lo = 8'h00; hi = 8'hFC; psel = 2'd0; start_a = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("midwr_was_writing", 32'(mw_a), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_mem_write", 32'(mw_a), 32'd0);
    check("midrst_busy", 32'(busy_a), 32'd0);
    check("midrst_dm_addr", 32'(addr_a), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    wrote = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (busy_a || mw_a) wrote = 1'b1;
    end
    check("held_start_no_relaunch", 32'(wrote), 32'd0);
    @(negedge clk); start_a = 1'b0;
    @(negedge clk); start_a = 1'b1;
    @(posedge clk); #1;
    check("relaunch_busy", 32'(busy_a), 32'd1);
    check("relaunch_write", 32'(mw_a), 32'd1);
    @(negedge clk);
    rst = 1'b0; start_a = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int r = 0; r < 10; r++) begin
      clear_faults();
      rl = 8'($urandom);
      rh = 8'($urandom);
      if (r < 7 && rh < rl) begin tmp = rl; rl = rh; rh = tmp; end
      for (int f = 0; f < 3; f++) begin
        tmp = 8'($urandom) & 8'hFC;
        if ($urandom_range(0, 1) == 0) andm[tmp] = ~(32'd1 << $urandom_range(0, 31));
        else                           orm[tmp]  = 32'd1 << $urandom_range(0, 31);
      end
      run(1'b0, rl, rh, 2'($urandom_range(0, 3)), $sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
